// File: rtl/risc_pkg.sv
// Shared types and default widths for the word-to-lane serializer.
package risc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_LANE_W = 8;

endpackage

// File: rtl/word_byte_serializer.sv
// Splits a WORD_W input word into NLANES lanes of LANE_W bits, sent one per
// output handshake, with a 1-cycle capture latency and gap-free back-to-back words.
module word_byte_serializer
    import risc_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int MSB_FIRST = 0,
    localparam int NLANES   = WORD_W / LANE_W,
    localparam int IDX_W    = ($clog2(NLANES) > 1) ? $clog2(NLANES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last,
    output logic [IDX_W-1:0]  out_index,
    output logic              busy,
    output logic [15:0]       word_count
);

    localparam int POS_W = ($clog2(WORD_W) > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLANES - 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [LANE_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         wc_q, wc_d;
    logic                in_hs, out_hs;

    // Send-order position k maps to a physical lane; MSB_FIRST reverses it.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                   input logic [IDX_W-1:0]  k);
        int                pos;
        logic [POS_W-1:0]  base;
        pos  = (MSB_FIRST != 0) ? (NLANES - 1 - int'(k)) : int'(k);
        base = POS_W'(pos * LANE_W);
        return w[base +: LANE_W];
    endfunction

    assign out_valid  = (state_q == ST_SHIFT);
    assign out_first  = out_valid && (idx_q == '0);
    assign out_last   = out_valid && (idx_q == LAST_IDX);
    assign out_data   = data_q;
    assign out_index  = idx_q;
    assign busy       = out_valid;
    assign word_count = wc_q;

    // Accept a new word while the last lane leaves, so words stream with no gap.
    assign in_ready = rst_n && !flush && ((state_q == ST_IDLE) || (out_last && out_ready));
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        data_d  = data_q;
        idx_d   = idx_q;
        wc_d    = wc_q;
        if (flush) begin
            // Flush drops the held word even if its last lane is handshaking.
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            if (out_hs) begin
                if (out_last) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    wc_d    = wc_q + 16'd1;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    data_d = lane_sel(word_q, idx_q + 1'b1);
                end
            end
            if (in_hs) begin
                state_d = ST_SHIFT;
                word_d  = in_data;
                idx_d   = '0;
                data_d  = lane_sel(in_data, '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
        end
    end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Scoreboard bench: three serializer instances (LSB-first, MSB-first, 64-bit).
module tb_word_byte_serializer;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] idx;
        logic       first;
        logic       last;
    } lane_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, out_ready, in_valid, in_valid2;
    logic [31:0] in_data;
    logic [63:0] in_data2;

    logic        r0, r1, r2, v0, v1, v2, f0, f1, f2, l0, l1, l2, b0, b1, b2;
    logic [7:0]  d0, d1, d2;
    logic [1:0]  x0, x1;
    logic [2:0]  x2;
    logic [15:0] wc0, wc1, wc2;

    word_byte_serializer #(.WORD_W(32), .LANE_W(8), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .flush(flush), .out_valid(v0), .out_ready(out_ready), .out_data(d0),
        .out_first(f0), .out_last(l0), .out_index(x0), .busy(b0), .word_count(wc0));

    word_byte_serializer #(.WORD_W(32), .LANE_W(8), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .flush(flush), .out_valid(v1), .out_ready(out_ready), .out_data(d1),
        .out_first(f1), .out_last(l1), .out_index(x1), .busy(b1), .word_count(wc1));

    word_byte_serializer #(.WORD_W(64), .LANE_W(8), .MSB_FIRST(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(r2), .in_data(in_data2),
        .flush(flush), .out_valid(v2), .out_ready(out_ready), .out_data(d2),
        .out_first(f2), .out_last(l2), .out_index(x2), .busy(b2), .word_count(wc2));

    lane_t q0[$], q1[$], q2[$];
    int passed = 0, total = 0;
    int cyc = 0, vc0 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fail_now(input string tag);
        total++;
        $error("FAIL %s: observed event, expected none", tag);
    endtask

    function automatic lane_t mk(input logic [7:0] d, input int k, input int n);
        lane_t t;
        t.d     = d;
        t.idx   = 3'(k);
        t.first = (k == 0);
        t.last  = (k == n - 1);
        return t;
    endfunction

    // Every valid cycle must match the scoreboard head; a handshake retires it.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (v0) begin
                vc0++;
                if (q0.size() == 0) fail_now("lsb unexpected lane");
                else begin
                    chk("lsb lane", 64'({d0, 1'b0, x0, f0, l0}), 64'(q0[0]));
                    if (out_ready) void'(q0.pop_front());
                end
            end else chk("lsb idle flags", 64'({f0, l0}), 64'd0);
            if (v1) begin
                if (q1.size() == 0) fail_now("msb unexpected lane");
                else begin
                    chk("msb lane", 64'({d1, 1'b0, x1, f1, l1}), 64'(q1[0]));
                    if (out_ready) void'(q1.pop_front());
                end
            end
            if (v2) begin
                if (q2.size() == 0) fail_now("w64 unexpected lane");
                else begin
                    chk("w64 lane", 64'({d2, x2, f2, l2}), 64'(q2[0]));
                    if (out_ready) void'(q2.pop_front());
                end
            end else chk("w64 idle flags", 64'({f2, l2}), 64'd0);
        end
    end

    task automatic send(input logic [63:0] w, input bit wide, input bit keep, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        if (wide) begin in_valid2 = 1'b1; in_data2 = w; end
        else      begin in_valid  = 1'b1; in_data  = w[31:0]; end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((wide ? r2 : r0) === 1'b1) begin
                got = 1'b1;
                if (wide) for (int k = 0; k < 8; k++) q2.push_back(mk(w[k*8 +: 8], k, 8));
                else for (int k = 0; k < 4; k++) begin
                    q0.push_back(mk(w[k*8 +: 8], k, 4));
                    q1.push_back(mk(w[(3-k)*8 +: 8], k, 4));
                end
                break;
            end
            waits++;
        end
        if (!got) fail_now("send timeout");
        @(posedge clk); #1;
        if (!keep || !got) begin in_valid = 1'b0; in_valid2 = 1'b0; end
    endtask

    task automatic drain(input bit toggle);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) begin
                done = 1'b1;
                break;
            end
            if (toggle) out_ready = pat[i % 4];
            @(posedge clk); #1;
        end
        if (!done) fail_now("drain timeout");
        out_ready = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c0, v_0, wc_prev;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_valid2 = 1'b0; in_data = '0; in_data2 = '0;

        // Reset state, with a word offered to prove in_ready is held low.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("in_ready during reset", 64'(r0), 64'd0);
        chk("reset out_valid", 64'(v0), 64'd0);
        chk("reset out_data", 64'(d0), 64'd0);
        chk("reset index/first/last", 64'({x0, f0, l0}), 64'd0);
        chk("reset busy", 64'(b0), 64'd0);
        chk("reset word_count", 64'(wc0), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // Scenarios 1 and 2: one word, LSB-first and MSB-first in parallel.
        send(64'hA1B2C3D4, 1'b0, 1'b0, w);
        c0 = cyc; v_0 = vc0;
        chk("s1 busy", 64'(b0), 64'd1);
        chk("s1 first lane", 64'({d0, f0}), 64'({8'hD4, 1'b1}));
        chk("s2 first lane", 64'({d1, f1}), 64'({8'hA1, 1'b1}));
        drain(1'b0);
        chk("s1 consecutive cycles", 64'(cyc - c0), 64'd4);
        chk("s1 valid cycles", 64'(vc0 - v_0), 64'd4);
        chk("s1 word_count", 64'(wc0), 64'd1);
        chk("s2 word_count", 64'(wc1), 64'd1);
        chk("s1 idle busy", 64'(b0), 64'd0);

        // Scenario 3: back-to-back words, in_valid held high.
        send(64'h11223344, 1'b0, 1'b1, w);
        c0 = cyc; v_0 = vc0;
        send(64'h55667788, 1'b0, 1'b0, w);
        chk("s3 second word waits", 64'(w), 64'd3);
        drain(1'b0);
        chk("s3 gapless cycles", 64'(cyc - c0), 64'd8);
        chk("s3 valid cycles", 64'(vc0 - v_0), 64'd8);
        chk("s3 word_count", 64'(wc0), 64'd3);

        // Scenario 4: stalls; scoreboard head check proves lanes stay stable.
        send(64'hDEADBEEF, 1'b0, 1'b0, w);
        drain(1'b1);
        chk("s4 word_count", 64'(wc0), 64'd4);

        // Scenario 5: flush during lane 1 drops the rest of the word.
        send(64'hCAFEF00D, 1'b0, 1'b0, w);
        @(posedge clk); #1;
        chk("s5 lane1 index", 64'(x0), 64'd1);
        wc_prev = 4;
        flush = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("s5 in_ready under flush", 64'(r0), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; out_ready = 1'b1;
        q0.delete(); q1.delete();
        chk("s5 out_valid after flush", 64'(v0), 64'd0);
        chk("s5 busy after flush", 64'(b0), 64'd0);
        chk("s5 word_count kept", 64'(wc0), 64'(wc_prev));
        send(64'h01020304, 1'b0, 1'b0, w);
        chk("s5 next first lane", 64'({d0, f0, x0}), 64'({8'h04, 1'b1, 2'd0}));
        drain(1'b0);
        chk("s5 word_count", 64'(wc0), 64'd5);
        chk("s5 msb word_count", 64'(wc1), 64'd5);

        // Scenario 6: reset mid-word, then a 64-bit word.
        send(64'h12345678, 1'b0, 1'b0, w);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q0.delete(); q1.delete();
        chk("s6 reset out_valid", 64'({v0, v1}), 64'd0);
        chk("s6 reset out_data", 64'({d0, d1}), 64'd0);
        chk("s6 reset index/first/last", 64'({x0, f0, l0}), 64'd0);
        chk("s6 reset busy", 64'({b0, b1}), 64'd0);
        chk("s6 reset word_count", 64'({wc0, wc1}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        send(64'h0807060504030201, 1'b1, 1'b0, w);
        chk("s6 w64 first lane", 64'({d2, f2, x2}), 64'({8'h01, 1'b1, 3'd0}));
        drain(1'b0);
        chk("s6 w64 word_count", 64'(wc2), 64'd1);
        chk("s6 lsb word_count", 64'(wc0), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
